tg_phase_controller: RTL
========================

# tg_phase_controller

Sequences one test run for the traffic generator and the PIFO drain logic: a generate phase of programmed length, then a drain phase, then done. Drives the generator's generate-phase strobe and phase count directly. Watches the generator's sent count and the sink's received count to decide when the run is complete. Sits upstream of the traffic generator; its drain enable feeds the dequeue/sink side of the bench.

## Interface
Parameters:
- DRAIN_TIMEOUT, default 4096: maximum drain-phase cycles before forced completion; only used with the timeout feature compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i__start  in  1  one-cycle pulse; starts a run from IDLE or DONE.
- i__abort  in  1  returns the block to IDLE from any state.
- i__gen_cycles  in  CounterSignal  length of the generate phase, in cycles.
- i__num_pkts_sent  in  CounterSignal  packets accepted by the PIFO, as counted by the generator.
- i__total_packets  in  CounterSignal  same value as the generator's configured packet budget.
- i__num_pkts_recv  in  CounterSignal  packets dequeued, as counted by the sink.
- o__generate_phase  out  1  high for every generate-phase cycle.
- o__phase_count  out  CounterSignal  index of the current generate cycle; 0 in the first cycle.
- o__drain_phase  out  1  high in DRAIN; enables PIFO dequeue.
- o__done  out  1  high in DONE.
- o__timeout  out  1  sticky; set when the drain phase times out.
- o__state  out  2  encoded state: IDLE=0, GENERATE=1, DRAIN=2, DONE=3.

## Operation
State register and counters:
- All outputs are Moore, decoded from registered state and counters.
- Reset values: state IDLE; o__phase_count 0; drain counter 0; o__timeout 0; every output low except o__state=0.

IDLE:
- All phase outputs low.
- i__start with i__gen_cycles>0 goes to GENERATE and clears o__phase_count.
- i__start with i__gen_cycles==0 goes straight to DRAIN.

GENERATE:
- o__generate_phase=1.
- o__phase_count increments by 1 per cycle and saturates at all-ones.
- Go to DRAIN when o__phase_count == i__gen_cycles-1, or when i__num_pkts_sent >= i__total_packets (early exit), whichever comes first.

DRAIN:
- o__drain_phase=1; the drain counter starts at 0 and increments each cycle.
- Go to DONE when i__num_pkts_recv >= i__num_pkts_sent. Evaluated every cycle, including the first DRAIN cycle.
- Timeout: when the drain counter reaches DRAIN_TIMEOUT-1 without completion, go to DONE and set o__timeout.

DONE:
- o__done=1; all counters hold.
- i__start starts a new run, taking the same IDLE-style transition: clears o__timeout, o__phase_count and the drain counter.

Priority of simultaneous events:
- Abort has top priority: i__abort in any state goes to IDLE next cycle and clears all counters and o__timeout, even if i__start is asserted the same cycle.
- In GENERATE, if both exit conditions hold in the same cycle, the single transition is to DRAIN.
- In DRAIN, if completion and timeout coincide, completion wins and o__timeout stays 0.
- i__start is ignored in GENERATE and DRAIN.

Comparisons are unsigned at full CounterSignal width.

## Timing
- i__start sampled high at edge t: o__generate_phase is high from cycle t+1 for exactly i__gen_cycles cycles, with o__phase_count running 0..i__gen_cycles-1.
- Early exit: i__num_pkts_sent reaching the budget in cycle k makes cycle k+1 the first DRAIN cycle.
- Completion: if i__num_pkts_recv catches up in cycle k, o__done is high from cycle k+1.
- Reset deassertion: the first active edge after deassertion sees IDLE; reset asserted mid-run forces IDLE with no edge required.

## Configuration
- PHASE_CTRL_TIMEOUT_EN defined: drain counter and timeout exit compiled in, as described above.
- PHASE_CTRL_TIMEOUT_EN undefined: no drain counter; DRAIN waits indefinitely for completion; o__timeout tied to 0; DRAIN_TIMEOUT unused.

## Test plan
- Basic run: gen_cycles=8, total=100, sent stays 3, recv rises to 3 after 5 DRAIN cycles -> generate_phase high 8 cycles, phase_count 0..7, DONE on the cycle after recv=3, timeout=0.
- Early exit: gen_cycles=50, total=4, sent reaches 4 in generate cycle 10 -> DRAIN from the next cycle, phase_count last value 10.
- Zero length: gen_cycles=0 with start -> IDLE to DRAIN directly, generate_phase never high; with sent=recv=0, DONE one cycle later.
- Timeout (macro defined, DRAIN_TIMEOUT=16): recv held below sent -> DONE after exactly 16 DRAIN cycles, timeout=1; a following start clears it.
- Abort/reset: abort asserted together with start in DRAIN -> IDLE next cycle, counters 0; async reset asserted mid-GENERATE -> outputs immediately at reset values.

Source files
------------

// File: rtl/tg_phase_controller.sv
// -----------------------------------------------------------------------------
// tg_phase_controller
//
// Sequences one traffic-generator test run: a generate phase of programmed
// length, a drain phase that waits for the sink to catch up with the
// generator, then done. All outputs are Moore, decoded from registered state.
//
// Optional feature: define PHASE_CTRL_TIMEOUT_EN to compile in the drain
// counter and the forced drain-phase completion after DRAIN_TIMEOUT cycles.
// Without it, DRAIN waits indefinitely and o__timeout is tied low.
//
// Parameters:
//   CNT_W          width of every counter-valued port (CounterSignal)
//   DRAIN_TIMEOUT  maximum drain-phase cycles before forced completion
//
// Ports:
//   clk                clock, rising edge
//   reset              asynchronous active-low reset
//   i__start           one-cycle pulse; starts a run from IDLE or DONE
//   i__abort           return to IDLE from any state, clearing counters
//   i__gen_cycles      generate-phase length in cycles
//   i__num_pkts_sent   packets accepted by the PIFO (generator count)
//   i__total_packets   generator packet budget
//   i__num_pkts_recv   packets dequeued (sink count)
//   o__generate_phase  high for every generate-phase cycle
//   o__phase_count     index of the current generate cycle
//   o__drain_phase     high in DRAIN; enables PIFO dequeue
//   o__done            high in DONE
//   o__timeout         sticky drain-timeout flag
//   o__state           IDLE=0, GENERATE=1, DRAIN=2, DONE=3
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no run active; waiting for start
// GENERATE | generator strobed; phase count advancing
// DRAIN    | dequeue enabled; waiting for recv to reach sent
// DONE     | run finished; counters hold until start or abort
// -----------------------------------------------------------------------------
module tg_phase_controller #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i__start,
    input  logic             i__abort,
    input  logic [CNT_W-1:0] i__gen_cycles,
    input  logic [CNT_W-1:0] i__num_pkts_sent,
    input  logic [CNT_W-1:0] i__total_packets,
    input  logic [CNT_W-1:0] i__num_pkts_recv,
    output logic             o__generate_phase,
    output logic [CNT_W-1:0] o__phase_count,
    output logic             o__drain_phase,
    output logic             o__done,
    output logic             o__timeout,
    output logic [1:0]       o__state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GENERATE = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_nxt;
    logic             gen_exit;
    logic             drain_complete;

    // Phase count never advances past the cycle that leaves GENERATE, so the
    // last generate index stays visible during DRAIN and DONE.
    assign gen_exit = (phase_cnt == (i__gen_cycles - CNT_W'(1))) ||
                      (i__num_pkts_sent >= i__total_packets);
    assign drain_complete = (i__num_pkts_recv >= i__num_pkts_sent);

`ifdef PHASE_CTRL_TIMEOUT_EN
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

    logic [31:0] drain_cnt, drain_nxt;
    logic        timeout_q, timeout_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            drain_cnt <= drain_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign o__timeout = timeout_q;
`else
    // DRAIN_TIMEOUT has no effect without the drain counter.
    logic unused_drain_timeout;
    assign unused_drain_timeout = ^DRAIN_TIMEOUT;
    assign o__timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
`ifdef PHASE_CTRL_TIMEOUT_EN
        drain_nxt   = drain_cnt;
        timeout_nxt = timeout_q;
`endif
        if (i__abort) begin
            state_nxt = S_IDLE;
            phase_nxt = '0;
`ifdef PHASE_CTRL_TIMEOUT_EN
            drain_nxt   = '0;
            timeout_nxt = 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i__start) begin
                        phase_nxt = '0;
`ifdef PHASE_CTRL_TIMEOUT_EN
                        drain_nxt   = '0;
                        timeout_nxt = 1'b0;
`endif
                        state_nxt = (i__gen_cycles != '0) ? S_GENERATE : S_DRAIN;
                    end
                end
                S_GENERATE: begin
                    if (gen_exit) begin
                        state_nxt = S_DRAIN;
`ifdef PHASE_CTRL_TIMEOUT_EN
                        drain_nxt = '0;
`endif
                    end else if (phase_cnt != '1) begin
                        phase_nxt = phase_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Completion is checked first so it wins over a
                    // coincident timeout.
                    if (drain_complete) begin
                        state_nxt = S_DONE;
`ifdef PHASE_CTRL_TIMEOUT_EN
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end else begin
                        drain_nxt = drain_cnt + 32'd1;
`endif
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign o__state          = state;
    assign o__phase_count    = phase_cnt;
    assign o__generate_phase = (state == S_GENERATE);
    assign o__drain_phase    = (state == S_DRAIN);
    assign o__done           = (state == S_DONE);

endmodule
